// File: rtl/hazard_scheduler_if.sv
// Handshake bundle between the ID/EX pipeline control and the hazard scheduler.
interface hazard_scheduler_if;
  logic        id_valid;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_regwrite;
  logic        id_is_load;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        ex_redirect;
  logic        mem_busy;
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] redirect_cnt;

  modport slave (
    input  id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load,
    input  id_rs1, id_rs2, id_rd, ex_redirect, mem_busy,
    output pc_we, ifid_we, idex_we, ifid_flush, idex_flush,
    output fwd_a, fwd_b, state, stall_cnt, redirect_cnt
  );

  modport master (
    output id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load,
    output id_rs1, id_rs2, id_rd, ex_redirect, mem_busy,
    input  pc_we, ifid_we, idex_we, ifid_flush, idex_flush,
    input  fwd_a, fwd_b, state, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard scheduler: load-use stall, redirect flush, memory-wait freeze and
// registered forwarding selects for a classic 5-stage in-order pipeline.
module hazard_scheduler #(
  parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       vld;
  } slot_t;

  state_e      state_q, state_d;
  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  logic        pc_we, ifid_we, idex_we, ifid_flush, idex_flush;
  logic        load_use;

  // x0 is hardwired zero, so a producer targeting it never forwards.
  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.vld & s.wr & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  // Saturating increment for the performance counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= CNT_SAT) ? v : v + 16'd1;
  endfunction

  // Youngest producer (EX) wins over the older one (MEM).
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input slot_t ex_s, input slot_t mem_s);
    if (use_r && slot_match(ex_s, r)) begin
      return 2'd1;
    end else if (use_r && slot_match(mem_s, r)) begin
      return 2'd2;
    end
    return 2'd0;
  endfunction

  // Load in EX whose result the ID instruction needs immediately.
  always_comb begin
    load_use = bus.id_valid & ex_q.ld &
               ((bus.id_use_rs1 & slot_match(ex_q, bus.id_rs1)) |
                (bus.id_use_rs2 & slot_match(ex_q, bus.id_rs2)));
  end

  // Priority decode: mem_busy > ex_redirect > load-use > normal advance.
  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idex_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    state_d        = ST_RUN;
    ex_d           = ex_q;
    mem_d          = mem_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (!reset) begin
      // Held in reset: outputs stay at the free-running defaults.
      state_d = ST_RUN;
    end else if (bus.mem_busy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      state_d = ST_MEM_WAIT;
    end else if (bus.ex_redirect) begin
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      mem_d          = ex_q;
      ex_d           = '0;
      fwd_a_d        = 2'd0;
      fwd_b_d        = 2'd0;
      redirect_cnt_d = sat_inc(redirect_cnt_q);
      state_d        = ST_REDIRECT;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_flush  = 1'b1;
      mem_d       = ex_q;
      ex_d        = '0;
      fwd_a_d     = 2'd0;
      fwd_b_d     = 2'd0;
      stall_cnt_d = sat_inc(stall_cnt_q);
      state_d     = ST_LU_STALL;
    end else begin
      mem_d   = ex_q;
      ex_d    = '{rd: bus.id_rd, wr: bus.id_regwrite, ld: bus.id_is_load, vld: bus.id_valid};
      fwd_a_d = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
      fwd_b_d = fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
      state_d = ST_RUN;
    end
  end

  // State, tracker, forwarding selects and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      ex_q           <= '0;
      mem_q          <= '0;
      fwd_a_q        <= 2'd0;
      fwd_b_q        <= 2'd0;
      stall_cnt_q    <= 16'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.ifid_we      = ifid_we;
  assign bus.idex_we      = idex_we;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.fwd_a        = fwd_a_q;
  assign bus.fwd_b        = fwd_b_q;
  assign bus.state        = state_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule
